// File: rtl/xpm_sdpram_pkg.sv
// Shared types and elaboration-time helpers for the behavioural simple-dual-port RAM.
package xpm_sdpram_pkg;

  typedef enum logic [1:0] {WR_FIRST, RD_FIRST, NO_CHANGE} wr_mode_e;

  function automatic wr_mode_e str2mode(input string s);
    if (s == "read_first") return RD_FIRST;
    if (s == "no_change") return NO_CHANGE;
    return WR_FIRST;
  endfunction

  function automatic bit mode_legal(input string s);
    return (s == "write_first") || (s == "read_first") || (s == "no_change");
  endfunction

  function automatic int calc_nb(input int dw, input int bww);
    return dw / bww;
  endfunction

  function automatic int calc_depth(input int msize, input int dw);
    return msize / dw;
  endfunction

endpackage

// File: rtl/sdpram_out_pipe.sv
// Optional second read stage: loads on regce, asynchronously cleared to the reset value.
module sdpram_out_pipe #(
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  logic [DATA_WIDTH-1:0] s2_q = RESET_VALUE;
  logic [DATA_WIDTH-1:0] s2_d;

  always_comb begin
    s2_d = s2_q;
    if (ce_i) s2_d = d_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) s2_q <= RESET_VALUE;
    else       s2_q <= s2_d;
  end

  assign q_o = s2_q;

endmodule

// File: rtl/xpm_sdpram.sv
// Simple-dual-port RAM: byte-enabled write port A, registered read port B with
// configurable collision behaviour and 1- or 2-stage read latency.
module xpm_sdpram
  import xpm_sdpram_pkg::*;
#(
  parameter int                    ADDR_WIDTH       = 8,
  parameter int                    DATA_WIDTH       = 32,
  parameter int                    BYTE_WRITE_WIDTH = 32,
  parameter int                    MEMORY_SIZE      = 8192,
  parameter int                    READ_LATENCY_B   = 1,
  parameter string                 WRITE_MODE_B     = "write_first",
  parameter logic [DATA_WIDTH-1:0] READ_RESET_VALUE = '0,
  localparam int                   NB               = calc_nb(DATA_WIDTH, BYTE_WRITE_WIDTH)
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  ena,
  input  logic [NB-1:0]         wea,
  input  logic [ADDR_WIDTH-1:0] addra,
  input  logic [DATA_WIDTH-1:0] dina,
  input  logic                  enb,
  input  logic                  regceb,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] doutb,
  output logic                  sbiterrb,
  output logic                  dbiterrb
);

  localparam int       DEPTH = calc_depth(MEMORY_SIZE, DATA_WIDTH);
  localparam int       AIW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam wr_mode_e MODE  = str2mode(WRITE_MODE_B);

  if (READ_LATENCY_B != 1 && READ_LATENCY_B != 2) begin : g_bad_latency
    $error("xpm_sdpram: READ_LATENCY_B must be 1 or 2");
  end
  if ((BYTE_WRITE_WIDTH != 8 && BYTE_WRITE_WIDTH != DATA_WIDTH) ||
      (DATA_WIDTH % BYTE_WRITE_WIDTH != 0)) begin : g_bad_bww
    $error("xpm_sdpram: BYTE_WRITE_WIDTH must be 8 or DATA_WIDTH and divide DATA_WIDTH");
  end
  if (DEPTH < 1 || DEPTH > 2 ** ADDR_WIDTH) begin : g_bad_depth
    $error("xpm_sdpram: MEMORY_SIZE/DATA_WIDTH must be in 1..2**ADDR_WIDTH");
  end
  if (!mode_legal(WRITE_MODE_B)) begin : g_bad_mode
    $error("xpm_sdpram: WRITE_MODE_B must be write_first, read_first or no_change");
  end

  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] s1_q = READ_RESET_VALUE;
  logic [DATA_WIDTH-1:0] s1_d;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] wf_word;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  coll;

  assign wr_ok   = ena && (32'(addra) < DEPTH);
  assign rd_ok   = 32'(addrb) < DEPTH;
  assign rd_word = rd_ok ? mem_q[addrb[AIW-1:0]] : '0;
  assign coll    = wr_ok && (|wea) && enb && rd_ok && (addra == addrb);

  // Write-first view of the colliding word: fresh bytes where written, old elsewhere.
  for (genvar gi = 0; gi < NB; gi++) begin : g_wf_merge
    assign wf_word[gi*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] =
      wea[gi] ? dina[gi*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH]
              : rd_word[gi*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
  end

  always_ff @(posedge clka) begin
    if (wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (wea[i]) begin
          mem_q[addra[AIW-1:0]][i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH] <=
            dina[i*BYTE_WRITE_WIDTH +: BYTE_WRITE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    s1_d = s1_q;
    if (enb) begin
      if (!coll)                 s1_d = rd_word;
      else if (MODE == WR_FIRST) s1_d = wf_word;
      else if (MODE == RD_FIRST) s1_d = rd_word;
    end
  end

  always_ff @(posedge clka or posedge rstb) begin
    if (rstb) s1_q <= READ_RESET_VALUE;
    else      s1_q <= s1_d;
  end

  if (READ_LATENCY_B == 2) begin : g_lat2
    sdpram_out_pipe #(
      .DATA_WIDTH  (DATA_WIDTH),
      .RESET_VALUE (READ_RESET_VALUE)
    ) u_out_pipe (
      .clk_i (clka),
      .rst_i (rstb),
      .ce_i  (regceb),
      .d_i   (s1_q),
      .q_o   (doutb)
    );
  end else begin : g_lat1
    logic unused_regceb;
    assign unused_regceb = regceb;
    assign doutb = s1_q;
  end

  assign sbiterrb = 1'b0;
  assign dbiterrb = 1'b0;

endmodule

// File: tb/tb_xpm_sdpram.sv
// Three RAM flavours on shared stimulus, checked against a word/byte-mask memory model.
module tb_xpm_sdpram;

  localparam int DEPTH = 200;

  logic        clka = 1'b0;
  logic        rstb = 1'b0;
  logic        ena = 1'b0;
  logic [3:0]  wea = '0;
  logic [7:0]  addra = '0;
  logic [31:0] dina = '0;
  logic        enb = 1'b0;
  logic        regceb = 1'b0;
  logic [7:0]  addrb = '0;
  logic [31:0] dout_wf, dout_rf, dout_nc;
  logic [2:0]  sbit, dbit;

  int n_vec = 0;
  int n_err = 0;

  // Reference: memory contents plus what each flavour should be presenting.
  logic [31:0] mem_m [DEPTH];
  logic [31:0] s1_m [3];
  logic [31:0] s2_m;
  string       inst_name [3] = '{"wf_lat1", "rf_lat2", "nc_lat1"};

  always #5 clka = ~clka;

  xpm_sdpram #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WRITE_WIDTH(8), .MEMORY_SIZE(32*DEPTH),
               .READ_LATENCY_B(1), .WRITE_MODE_B("write_first"), .READ_RESET_VALUE(32'h0))
  u_wf (.clka(clka), .rstb(rstb), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .regceb(regceb), .addrb(addrb), .doutb(dout_wf),
        .sbiterrb(sbit[0]), .dbiterrb(dbit[0]));

  xpm_sdpram #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WRITE_WIDTH(8), .MEMORY_SIZE(32*DEPTH),
               .READ_LATENCY_B(2), .WRITE_MODE_B("read_first"), .READ_RESET_VALUE(32'h0))
  u_rf (.clka(clka), .rstb(rstb), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .regceb(regceb), .addrb(addrb), .doutb(dout_rf),
        .sbiterrb(sbit[1]), .dbiterrb(dbit[1]));

  xpm_sdpram #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .BYTE_WRITE_WIDTH(8), .MEMORY_SIZE(32*DEPTH),
               .READ_LATENCY_B(1), .WRITE_MODE_B("no_change"), .READ_RESET_VALUE(32'h0))
  u_nc (.clka(clka), .rstb(rstb), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .enb(enb), .regceb(regceb), .addrb(addrb), .doutb(dout_nc),
        .sbiterrb(sbit[2]), .dbiterrb(dbit[2]));

  // Apply one cycle of inputs, advance the model across the edge, return at edge+1.
  task automatic step(input logic a_en, input logic [3:0] a_we, input logic [7:0] a_ad,
                      input logic [31:0] a_d, input logic b_en, input logic b_ce,
                      input logic [7:0] b_ad);
    logic [31:0] old, wmask;
    logic        coll;
    ena = a_en; wea = a_we; addra = a_ad; dina = a_d;
    enb = b_en; regceb = b_ce; addrb = b_ad;
    @(posedge clka);
    wmask = '0;
    for (int i = 0; i < 4; i++) if (a_en && a_we[i]) wmask[i*8 +: 8] = 8'hFF;
    old  = (b_ad < DEPTH) ? mem_m[b_ad] : 32'h0;
    coll = (wmask != 0) && b_en && (a_ad == b_ad) && (a_ad < DEPTH);
    if (!rstb) begin
      if (b_ce) s2_m = s1_m[1];
      if (b_en) begin
        s1_m[0] = coll ? ((old & ~wmask) | (a_d & wmask)) : old;
        s1_m[1] = old;
        if (!coll) s1_m[2] = old;
      end
    end
    if (a_en && a_ad < DEPTH) mem_m[a_ad] = (mem_m[a_ad] & ~wmask) | (a_d & wmask);
    #1;
  endtask

  task automatic idle(input logic ce);
    step(1'b0, 4'h0, 8'h0, 32'h0, 1'b0, ce, 8'h0);
  endtask

  task automatic test_reset();
    logic [31:0] got [3];
    got = '{dout_wf, dout_rf, dout_nc};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== 32'h0) begin
        n_err++; $display("FAIL reset_init %s: got %h want %h", inst_name[k], got[k], 32'h0);
      end
    end
    step(1'b1, 4'hF, 8'd3, 32'h5A5A5A5A, 1'b0, 1'b1, 8'd0);
    step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b1, 8'd3);
    idle(1'b1);
    got = '{dout_wf, dout_rf, dout_nc};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== 32'h5A5A5A5A) begin
        n_err++; $display("FAIL reset_preload %s: got %h want %h", inst_name[k], got[k], 32'h5A5A5A5A);
      end
    end
    #1 rstb = 1'b1;
    s1_m = '{default: 32'h0}; s2_m = 32'h0;
    #1;
    got = '{dout_wf, dout_rf, dout_nc};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== 32'h0) begin
        n_err++; $display("FAIL reset_async %s: got %h want %h", inst_name[k], got[k], 32'h0);
      end
    end
    rstb = 1'b0;
    idle(1'b1);
    idle(1'b1);
    got = '{dout_wf, dout_rf, dout_nc};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== 32'h0) begin
        n_err++; $display("FAIL reset_hold %s: got %h want %h", inst_name[k], got[k], 32'h0);
      end
    end
    n_vec++;
    if ({sbit, dbit} !== 6'b0) begin
      n_err++; $display("FAIL ecc_flags: got %b want %b", {sbit, dbit}, 6'b0);
    end
  endtask

  task automatic test_basic();
    step(1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 1'b1, 8'h0);
    step(1'b0, 4'h0, 8'h0, 32'h0, 1'b1, 1'b1, 8'h10);
    n_vec++;
    if (dout_wf !== 32'hDEADBEEF || dout_nc !== 32'hDEADBEEF || dout_rf !== 32'h0) begin
      n_err++; $display("FAIL basic_lat1: got wf=%h nc=%h rf=%h want %h %h %h",
                        dout_wf, dout_nc, dout_rf, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);
    end
    idle(1'b1);
    n_vec++;
    if (dout_rf !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL basic_lat2: got %h want %h", dout_rf, 32'hDEADBEEF);
    end
  endtask

  task automatic test_byte_write();
    logic [31:0] got [3];
    step(1'b1, 4'hF, 8'd5, 32'h11223344, 1'b0, 1'b1, 8'd0);
    step(1'b1, 4'b0010, 8'd5, 32'hAAAAAAAA, 1'b0, 1'b1, 8'd0);
    step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b1, 8'd5);
    idle(1'b1);
    got = '{dout_wf, dout_rf, dout_nc};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== 32'h1122AA44) begin
        n_err++; $display("FAIL byte_write %s: got %h want %h", inst_name[k], got[k], 32'h1122AA44);
      end
    end
  endtask

  task automatic test_collision();
    logic [31:0] got [3];
    logic [31:0] want [3];
    step(1'b1, 4'hF, 8'd7, 32'h1, 1'b0, 1'b1, 8'd0);
    step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b1, 8'd5);
    idle(1'b1);
    step(1'b1, 4'hF, 8'd7, 32'h2, 1'b1, 1'b1, 8'd7);
    idle(1'b1);
    got  = '{dout_wf, dout_rf, dout_nc};
    want = '{32'h2, 32'h1, 32'h1122AA44};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== want[k]) begin
        n_err++; $display("FAIL collision_full %s: got %h want %h", inst_name[k], got[k], want[k]);
      end
    end
    step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b1, 8'd7);
    idle(1'b1);
    got = '{dout_wf, dout_rf, dout_nc};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== 32'h2) begin
        n_err++; $display("FAIL collision_reread %s: got %h want %h", inst_name[k], got[k], 32'h2);
      end
    end
    step(1'b1, 4'b0001, 8'd7, 32'hFFFFFF33, 1'b1, 1'b1, 8'd7);
    idle(1'b1);
    got  = '{dout_wf, dout_rf, dout_nc};
    want = '{32'h33, 32'h2, 32'h2};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== want[k]) begin
        n_err++; $display("FAIL collision_byte %s: got %h want %h", inst_name[k], got[k], want[k]);
      end
    end
    step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b1, 8'd7);
    idle(1'b1);
    got = '{dout_wf, dout_rf, dout_nc};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== 32'h33) begin
        n_err++; $display("FAIL collision_byte_reread %s: got %h want %h", inst_name[k], got[k], 32'h33);
      end
    end
  endtask

  task automatic test_regce();
    step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b1, 8'd5);
    idle(1'b1);
    n_vec++;
    if (dout_rf !== 32'h1122AA44) begin
      n_err++; $display("FAIL regce_load: got %h want %h", dout_rf, 32'h1122AA44);
    end
    step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b0, 8'h10);
    idle(1'b0);
    n_vec++;
    if (dout_rf !== 32'h1122AA44 || dout_wf !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL regce_hold: got rf=%h wf=%h want %h %h",
                        dout_rf, dout_wf, 32'h1122AA44, 32'hDEADBEEF);
    end
    idle(1'b1);
    n_vec++;
    if (dout_rf !== 32'hDEADBEEF) begin
      n_err++; $display("FAIL regce_release: got %h want %h", dout_rf, 32'hDEADBEEF);
    end
  endtask

  task automatic test_reset_midread();
    logic [31:0] got [3];
    step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b1, 8'd3);
    rstb = 1'b1;
    s1_m = '{default: 32'h0}; s2_m = 32'h0;
    #1 rstb = 1'b0;
    #1;
    got = '{dout_wf, dout_rf, dout_nc};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== 32'h0) begin
        n_err++; $display("FAIL midread_reset %s: got %h want %h", inst_name[k], got[k], 32'h0);
      end
    end
    idle(1'b1);
    n_vec++;
    if (dout_rf !== 32'h0) begin
      n_err++; $display("FAIL midread_discard: got %h want %h", dout_rf, 32'h0);
    end
    step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b1, 8'd3);
    idle(1'b1);
    got = '{dout_wf, dout_rf, dout_nc};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== 32'h5A5A5A5A) begin
        n_err++; $display("FAIL midread_intact %s: got %h want %h", inst_name[k], got[k], 32'h5A5A5A5A);
      end
    end
  endtask

  task automatic test_addr_range();
    logic [31:0] got [3];
    step(1'b1, 4'hF, 8'd250, 32'hCAFEF00D, 1'b0, 1'b1, 8'd0);
    step(1'b1, 4'hF, 8'd199, 32'h12345678, 1'b0, 1'b1, 8'd0);
    step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b1, 8'd250);
    idle(1'b1);
    got = '{dout_wf, dout_rf, dout_nc};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== 32'h0) begin
        n_err++; $display("FAIL range_over %s: got %h want %h", inst_name[k], got[k], 32'h0);
      end
    end
    step(1'b0, 4'h0, 8'd0, 32'h0, 1'b1, 1'b1, 8'd199);
    idle(1'b1);
    got = '{dout_wf, dout_rf, dout_nc};
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if (got[k] !== 32'h12345678) begin
        n_err++; $display("FAIL range_last %s: got %h want %h", inst_name[k], got[k], 32'h12345678);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] got [3];
    logic [31:0] want [3];
    logic [7:0]  a_ad, b_ad;
    for (int n = 0; n < 400; n++) begin
      a_ad = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(195, 255)) : 8'($urandom_range(0, 7));
      b_ad = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(195, 255)) : 8'($urandom_range(0, 7));
      step(1'($urandom_range(0, 9) < 7), 4'($urandom), a_ad, $urandom,
           1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 8), b_ad);
      if ($urandom_range(0, 49) == 0) begin
        rstb = 1'b1;
        s1_m = '{default: 32'h0}; s2_m = 32'h0;
        #1 rstb = 1'b0;
      end
      got  = '{dout_wf, dout_rf, dout_nc};
      want = '{s1_m[0], s2_m, s1_m[2]};
      for (int k = 0; k < 3; k++) begin
        n_vec++;
        if (got[k] !== want[k]) begin
          n_err++; $display("FAIL random[%0d] %s: got %h want %h", n, inst_name[k], got[k], want[k]);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = 32'h0;
    s1_m = '{default: 32'h0};
    s2_m = 32'h0;
    #1;
    test_reset();
    test_basic();
    test_byte_write();
    test_collision();
    test_regce();
    test_reset_midread();
    test_addr_range();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
